// File: rtl/tt_wokwi_380408774591779841.sv
// Audio tone generator: a 16-bit phase counter is scaled by a power of two
// into an 8-bit sawtooth or triangle sample. A first-order sigma-delta
// modulator turns that sample into a 1-bit PDM stream on uio_out[7].
// The sample is also mirrored on uo_out.
module tt_wokwi_380408774591779841 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PHASE_W = 16;
    localparam int DATA_W  = 8;

    // Fold the upper half of the ramp back down so one period of p gives
    // one up-and-down sweep at twice the ramp slope.
    function automatic logic [DATA_W-1:0] tri_fold(input logic [DATA_W-1:0] p);
        return p[DATA_W-1] ? {~p[DATA_W-2:0], 1'b0} : {p[DATA_W-2:0], 1'b0};
    endfunction

    logic [3:0]         shift_by;
    logic               mute;
    logic               wave_sel;

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [DATA_W-1:0]  sample_q, sample_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic               pdm_q, pdm_d;

    logic [PHASE_W-1:0] shifted;
    logic [DATA_W-1:0]  p;
    logic [DATA_W:0]    sum;

    // Bits that are intentionally ignored by this design.
    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in, ui_in[3:2], shifted[PHASE_W-1:DATA_W]};

    assign shift_by = ui_in[7:4];
    assign mute     = ui_in[1];
    assign wave_sel = ui_in[0];

    // Next-state: phase advance, waveform shaping, and the PDM accumulator.
    always_comb begin
        phase_d  = phase_q + 16'd1;
        shifted  = phase_q >> shift_by;
        p        = shifted[DATA_W-1:0];
        sample_d = p;
        if (wave_sel) begin
            sample_d = tri_fold(p);
        end
        if (mute) begin
            sample_d = '0;
        end
        // The accumulator integrates the sample already on uo_out; the carry
        // out of the 8-bit add is the PDM bit, so ones density is S/256.
        sum   = {1'b0, acc_q} + {1'b0, sample_q};
        acc_d = sum[DATA_W-1:0];
        pdm_d = sum[DATA_W];
    end

    // State registers: reset wins over enable; ena=0 freezes everything.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            phase_q  <= '0;
            sample_q <= '0;
            acc_q    <= '0;
            pdm_q    <= 1'b0;
        end else if (ena) begin
            phase_q  <= phase_d;
            sample_q <= sample_d;
            acc_q    <= acc_d;
            pdm_q    <= pdm_d;
        end
    end

    assign uo_out  = sample_q;
    assign uio_out = {pdm_q, 7'b0};
    assign uio_oe  = 8'b1000_0000;

endmodule

// File: tb/tb_tt_wokwi_380408774591779841.sv
// Directed bench for the tone generator: reset values, sawtooth and triangle
// shapes, PDM latency and density, mute, phase wrap, enable freeze and
// mid-run reset.
module tb_tt_wokwi_380408774591779841;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;
    int ones;

    tt_wokwi_380408774591779841 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One reset edge, then release; the next edge is edge k=1.
    task automatic do_reset(input logic [7:0] cfg);
        ui_in = cfg;
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h5A;

        // Reset held for two edges.
        step();
        step();
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'h80);

        // Sawtooth, shift 0: after edge k the sample is (k-1) mod 256.
        rst_n = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            step();
            chk("saw0", uo_out, 32'((k - 1) & 255));
            // First PDM carry: accumulator reaches 276 at edge 25.
            if (k == 24) chk("pdm_e24", uio_out, 8'h00);
            if (k == 25) chk("pdm_e25", uio_out, 8'h80);
            if (k == 26) chk("pdm_e26", uio_out, 8'h00);
        end

        // Sawtooth, shift 2: each value held for four edges.
        do_reset(8'h20);
        for (int k = 1; k <= 40; k++) begin
            step();
            chk("saw2", uo_out, 32'(((k - 1) >> 2) & 255));
        end

        // Triangle, shift 0.
        do_reset(8'h01);
        for (int k = 1; k <= 257; k++) begin
            step();
            if (k == 1)     chk("tri_p00", uo_out, 8'h00);
            if (k == 'h41)  chk("tri_p40", uo_out, 8'h80);
            if (k == 'h80)  chk("tri_p7f", uo_out, 8'hFE);
            if (k == 'h81)  chk("tri_p80", uo_out, 8'hFE);
            if (k == 'h100) chk("tri_pff", uo_out, 8'h00);
            if (k == 'h101) chk("tri_p100", uo_out, 8'h00);
        end

        // PDM density, shift 8: sample 0x40 feeds the adder on edges
        // 0x4002..0x4101, which must yield exactly 64 ones.
        do_reset(8'h80);
        ones = 0;
        for (int k = 1; k <= 'h4101; k++) begin
            step();
            if (k == 'h4000) chk("dens_pre", uo_out, 8'h3F);
            if (k == 'h4001) chk("dens_s40", uo_out, 8'h40);
            if (k >= 'h4002) begin
                if (uio_out[7]) ones++;
                if (k == 'h4002) chk("dens_low", 32'(uio_out[6:0]), 32'h0);
            end
        end
        chk("dens_ones", 32'(ones), 32'd64);

        // Mute from a nonzero sample: sample drops to 0 on the first edge,
        // PDM is 0 from the second edge onward.
        ui_in = 8'h82;
        for (int k = 1; k <= 300; k++) begin
            step();
            chk("mute_uo", uo_out, 8'h00);
            if (k >= 2) chk("mute_pdm", uio_out, 8'h00);
        end

        // Enable freeze at edge 25 (sample 24, pdm 1), then resume.
        do_reset(8'h00);
        for (int k = 1; k <= 25; k++) step();
        chk("pre_hold_uo", uo_out, 8'd24);
        chk("pre_hold_uio", uio_out, 8'h80);
        ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("hold_uo", uo_out, 8'd24);
            chk("hold_uio", uio_out, 8'h80);
        end
        ena = 1'b1;
        step();
        chk("resume_uo", uo_out, 8'd25);
        chk("resume_uio", uio_out, 8'h00);

        // Single reset edge mid-run.
        for (int k = 0; k < 4; k++) step();
        chk("prerst_uo", uo_out, 8'd29);
        rst_n = 1'b1;
        step();
        chk("midrst_uo", uo_out, 8'h00);
        chk("midrst_uio", uio_out, 8'h00);
        chk("midrst_oe", uio_oe, 8'h80);
        rst_n = 1'b0;
        step();
        chk("post_rst1", uo_out, 8'h00);
        step();
        chk("post_rst2", uo_out, 8'h01);

        // Full phase wrap with shift 0.
        do_reset(8'h00);
        for (int k = 1; k <= 65540; k++) begin
            step();
            if (k >= 65530) chk("wrap", uo_out, 32'((k - 1) & 255));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_wokwi_380408774591779841.md
Name: tt_wokwi_380408774591779841

Overview:
- Tiny-Tapeout-style audio tone generator.
- A free-running 16-bit phase counter, divided by a programmable power of two, produces an 8-bit sawtooth or triangle sample.
- A first-order sigma-delta modulator converts the sample into a 1-bit PDM stream on uio_out[7].
- The current sample is mirrored on uo_out for observation and debug.

Parameters:
- None. All widths are fixed: 16-bit phase counter, 8-bit sample, 8-bit PDM accumulator.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-high (asserted when 1)
- ena  input  1  enable; when 0, all state holds
- ui_in  input  8  [7:4] shift_by (0..15); [1] mute; [0] wave_sel (0 = sawtooth, 1 = triangle); [3:2] ignored
- uio_in  input  8  ignored
- uo_out  output  8  registered current sample
- uio_out  output  8  [7] = pdm_output (registered); [6:0] = 0
- uio_oe  output  8  constant 8'b1000_0000 (only bit 7 driven)

Behaviour:
- Reset (rst_n=1 at a clock edge): phase=0, sample=0, pdm_acc=0, pdm_output=0, uo_out=0. Reset has priority over ena.
- Per rising edge with rst_n=0 and ena=1, these updates are simultaneous (all RHS use pre-edge values):
  - phase <= phase + 1, wrapping 0xFFFF -> 0x0000.
  - p = (phase >> shift_by)[7:0]. Logical shift, zero fill. shift_by=15 leaves only phase[15] in p[0].
  - Sawtooth (wave_sel=0): s = p.
  - Triangle (wave_sel=1): s = p[7] ? {~p[6:0],1'b0} : {p[6:0],1'b0}.
  - Mute (mute=1): s = 0, regardless of wave_sel.
  - sample <= s.
  - {carry, sum[7:0]} = pdm_acc + sample (9-bit add, old sample value).
  - pdm_acc <= sum[7:0]; pdm_output <= carry.
- Latency:
  - sample reflects phase value from 1 cycle earlier.
  - pdm_output reflects sample from 1 cycle earlier (2 cycles from phase).
- Ones density: over any 256 consecutive cycles with sample constant at S, pdm_output is 1 exactly S times.
  - S=0 gives constant 0.
  - S=255 gives 255 ones per 256 cycles.
- ena=0: phase, sample, pdm_acc, pdm_output all hold; outputs keep last values.
- ui_in changes take effect on the next edge. No synchronization stage is inserted.
- Reset mid-operation: all state returns to zero on that edge; counting resumes from 0 on the first non-reset enabled edge.
- uo_out = sample. uio_out = {pdm_output, 7'b0}. uio_oe constant, including during reset.

Test Plan:
1. Reset: hold rst_n=1 for 2 cycles with ena=1 -> uo_out=0x00, uio_out=0x00, uio_oe=0x80.
2. Sawtooth: shift_by=0, wave_sel=0, mute=0; release reset -> uo_out = 0,1,2,...,255,0 on successive edges (value after edge k is k-1 mod 256). With shift_by=2, each value repeats 4 cycles.
3. Triangle: shift_by=0, wave_sel=1 -> uo_out=0xFE when phase was 0x7F and when phase was 0x80; uo_out=0x00 when phase was 0xFF.
4. PDM density: shift_by=8, wave_sel=0, run until phase[15:8]=0x40 -> during the 256-cycle window where sample=0x40, count pdm_output ones = 64 (±1 at window edges).
5. Mute and boundaries: mute=1 for 300 cycles -> uo_out=0 and pdm_output=0 throughout. Force phase wrap (run 65536 cycles, shift_by=0) -> uo_out continues 0xFF -> 0x00 with no glitch.
6. Enable and reset interaction: drop ena for 10 cycles mid-count -> uo_out and uio_out frozen; resume continues from held value. Assert rst_n for one edge mid-run -> next edge uo_out=0.
